mod_sq_scheduler: RTL and testbench

//  Shares one mod_squared_unit (15x15 fixed multiply, 30b result) between NUM_CH radar I/Q

---
 rtl/mod_sq_pkg.sv | 8 +
 rtl/mod_sq_if.sv | 26 ++
 rtl/mod_sq_scheduler_rr_arbiter.sv | 26 ++
 rtl/mod_sq_scheduler.sv | 89 ++++++++
 tb/tb_mod_sq_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_sq_pkg.sv
// mod_sq_pkg: shared types and widths for the |s|^2 scheduler
package mod_sq_pkg;
    localparam int SAMPLE_W = 15;
    localparam int PROD_W   = 30;
    localparam int SUM_W    = 31;
    localparam int MASK_W   = 8;
    typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_Q, DRAIN, OUT} state_t;
endpackage

// File: rtl/mod_sq_if.sv
// mod_sq_if: channel, multiplier, config and result bus of the scheduler
interface mod_sq_if #(parameter int NUM_CH = 4, parameter int CH_W = 2);
    logic [NUM_CH-1:0]                      in_valid;
    logic [NUM_CH-1:0]                      in_ready;
    logic [NUM_CH*mod_sq_pkg::SAMPLE_W-1:0] in_i;
    logic [NUM_CH*mod_sq_pkg::SAMPLE_W-1:0] in_q;
    logic [mod_sq_pkg::MASK_W-1:0]          cfg_mask;
    logic                                   cfg_load;
    logic [mod_sq_pkg::SAMPLE_W-1:0]        mul_x;
    logic [mod_sq_pkg::SAMPLE_W-1:0]        mul_y;
    logic [mod_sq_pkg::MASK_W-1:0]          mul_mask;
    logic [mod_sq_pkg::PROD_W-1:0]          mul_r;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [mod_sq_pkg::SUM_W-1:0]           out_data;
    logic [CH_W-1:0]                        out_ch;
    logic                                   busy;
    modport slave (
        input  in_valid, in_i, in_q, cfg_mask, cfg_load, mul_r, out_ready,
        output in_ready, mul_x, mul_y, mul_mask, out_valid, out_data, out_ch, busy
    );
    modport master (
        output in_valid, in_i, in_q, cfg_mask, cfg_load, mul_r, out_ready,
        input  in_ready, mul_x, mul_y, mul_mask, out_valid, out_data, out_ch, busy
    );
endinterface

// File: rtl/mod_sq_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first requester at or after the pointer, combinational
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);
    // scan from the far end back toward the pointer so the nearest requester wins
    always_comb begin
        int c;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr_i) + k) % N;
            if (req_i[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = W'(c);
            end
        end
    end
endmodule

// File: rtl/mod_sq_scheduler.sv
// mod_sq_scheduler: round-robin shares one squaring multiplier between I/Q channels
module mod_sq_scheduler
    import mod_sq_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int MUL_LAT = 1
) (
    input logic     clk,
    input logic     rst,
    mod_sq_if.slave bus
);
    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   gnt;
    logic [CH_W-1:0]     gidx;
    logic [CH_W-1:0]     rr_q;
    logic [CH_W-1:0]     ch_q;
    logic [SAMPLE_W-1:0] i_q;
    logic [SAMPLE_W-1:0] q_q;
    logic [2:0]          cnt_q;
    logic [SUM_W-1:0]    sum_q;
    logic [MASK_W-1:0]   pend_q;
    logic [MASK_W-1:0]   act_q;
    logic                take;
    logic                run;

    rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
        .req_i (bus.in_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    assign take          = (state_q == IDLE) && |bus.in_valid;
    assign run           = (state_q == ISSUE_I) || (state_q == ISSUE_Q) || (state_q == DRAIN);
    assign bus.in_ready  = (state_q == IDLE) ? gnt : '0;
    assign bus.mul_x     = (state_q == ISSUE_I) ? i_q : (state_q == ISSUE_Q) ? q_q : '0;
    assign bus.mul_y     = bus.mul_x;
    assign bus.mul_mask  = act_q;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = sum_q;
    assign bus.out_ch    = ch_q;
    assign bus.busy      = (state_q != IDLE);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state: one transaction in flight; DRAIN ends once the Q product is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = take ? ISSUE_I : IDLE;
            ISSUE_I: state_d = ISSUE_Q;
            ISSUE_Q: state_d = DRAIN;
            DRAIN:   state_d = (cnt_q == 3'(MUL_LAT + 1)) ? OUT : DRAIN;
            OUT:     state_d = bus.out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    // capture, pointer, config, latency counter and product accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= '0;
            ch_q   <= '0;
            i_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            if (take) begin
                i_q  <= bus.in_i[int'(gidx)*SAMPLE_W +: SAMPLE_W];
                q_q  <= bus.in_q[int'(gidx)*SAMPLE_W +: SAMPLE_W];
                ch_q <= gidx;
                rr_q <= (int'(gidx) == NUM_CH - 1) ? '0 : gidx + 1'b1;
            end
            if (state_q == IDLE) act_q <= pend_q;
            if (bus.cfg_load) pend_q <= bus.cfg_mask;
            cnt_q <= run ? cnt_q + 1'b1 : '0;
            if (run && cnt_q == 3'(MUL_LAT)) sum_q <= SUM_W'(bus.mul_r);
            else if (run && cnt_q == 3'(MUL_LAT + 1)) sum_q <= sum_q + SUM_W'(bus.mul_r);
        end
    end
endmodule

// File: tb/tb_mod_sq_scheduler.sv
// tb_mod_sq_scheduler: directed and random checks against a transaction-level model
module tb_mod_sq_scheduler;
    localparam int N   = 4;
    localparam int CW  = 2;
    localparam int LAT = 1;
    localparam int OUT_PH = 3 + LAT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mod_sq_if #(.NUM_CH(N), .CH_W(CW)) bus ();

    mod_sq_scheduler #(.NUM_CH(N), .CH_W(CW), .MUL_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // behavioural squaring unit with LAT register stages
    logic [29:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= bus.mul_x * bus.mul_y;
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign bus.mul_r = mp[LAT-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // transaction-level reference: ph counts cycles since grant, 0 means idle
    int          ph = 0;
    int          ptr = 0;
    int          g;
    int          ech = 0;
    logic [7:0]  pend = 8'h00;
    logic [7:0]  act = 8'h00;
    logic [14:0] ei = '0;
    logic [14:0] eq = '0;
    logic [30:0] edata = '0;
    logic [N-1:0] er;
    int          dut_grants[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_mul_x", bus.mul_x, 0);
            chk("rst_mul_mask", bus.mul_mask, 0);
            chk("rst_out_data", bus.out_data, 0);
            ph   = 0;
            ptr  = 0;
            pend = 8'h00;
            act  = 8'h00;
        end else begin
            g  = pick(bus.in_valid, ptr);
            er = (ph == 0 && g >= 0) ? N'(1) << g : '0;
            chk("in_ready", bus.in_ready, er);
            chk("busy", bus.busy, ph != 0);
            chk("mul_mask", bus.mul_mask, act);
            chk("mul_x", bus.mul_x, ph == 1 ? ei : ph == 2 ? eq : 15'd0);
            chk("mul_y", bus.mul_y, ph == 1 ? ei : ph == 2 ? eq : 15'd0);
            chk("out_valid", bus.out_valid, ph >= OUT_PH);
            if (ph >= OUT_PH) begin
                chk("out_data", bus.out_data, edata);
                chk("out_ch", bus.out_ch, ech);
            end
            for (int c = 0; c < N; c++) if (bus.in_ready[c]) dut_grants.push_back(c);
            if (ph == 0) begin
                act = pend;
                if (g >= 0) begin
                    ph    = 1;
                    ech   = g;
                    ei    = bus.in_i[15*g +: 15];
                    eq    = bus.in_q[15*g +: 15];
                    edata = 31'(ei) * 31'(ei) + 31'(eq) * 31'(eq);
                    ptr   = (g + 1) % N;
                end
            end else if (ph < OUT_PH) begin
                ph++;
            end else if (bus.out_ready) begin
                ph = 0;
            end
            if (bus.cfg_load) pend = bus.cfg_mask;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        chk("wait_out_valid", bus.out_valid, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic set_ch(input int c, input logic [14:0] i, input logic [14:0] q);
        bus.in_i[15*c +: 15] = i;
        bus.in_q[15*c +: 15] = q;
    endtask

    int n;

    initial begin
        bus.in_valid  = '0;
        bus.in_i      = '0;
        bus.in_q      = '0;
        bus.cfg_mask  = '0;
        bus.cfg_load  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        do_reset();

        // single transaction on ch1
        set_ch(1, 15'd3, 15'd4);
        bus.in_valid = 4'b0010;
        #1;
        chk("t1_ready", bus.in_ready, 4'b0010);
        step();
        bus.in_valid = '0;
        wait_out(n);
        chk("t1_latency", n, 2 + LAT);
        chk("t1_data", bus.out_data, 25);
        chk("t1_ch", bus.out_ch, 1);
        step();
        chk("t1_busy_after", bus.busy, 0);

        // round-robin with all channels requesting
        do_reset();
        for (int c = 0; c < N; c++) set_ch(c, 15'(c + 10), 15'(c + 20));
        dut_grants.delete();
        bus.in_valid = 4'hF;
        repeat (21) step();
        bus.in_valid = '0;
        repeat (6) step();
        chk("rr_count", dut_grants.size(), 5);
        if (dut_grants.size() >= 5)
            for (int k = 0; k < 5; k++) chk("rr_order", dut_grants[k], k % N);

        // backpressure
        bus.out_ready = 1'b0;
        set_ch(2, 15'd100, 15'd7);
        bus.in_valid = 4'b0100;
        step();
        bus.in_valid = '0;
        wait_out(n);
        bus.in_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, 31'd10049);
            chk("bp_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_next_grant", |bus.in_ready, 1);
        bus.in_valid = '0;
        repeat (6) step();

        // maximum magnitude
        set_ch(3, 15'h7FFF, 15'h7FFF);
        bus.in_valid = 4'b1000;
        step();
        bus.in_valid = '0;
        wait_out(n);
        chk("max_data", bus.out_data, 31'h7FFE0002);
        chk("max_ch", bus.out_ch, 3);
        repeat (2) step();

        // config load during DRAIN, then coincident with a grant
        do_reset();
        set_ch(0, 15'd1, 15'd2);
        bus.in_valid = 4'b0001;
        step();
        bus.in_valid = '0;
        step();
        step();
        bus.cfg_mask = 8'h03;
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        chk("cfg_drain_old", bus.mul_mask, 8'h00);
        step();
        chk("cfg_idle_old", bus.mul_mask, 8'h00);
        step();
        chk("cfg_applied", bus.mul_mask, 8'h03);
        set_ch(1, 15'd5, 15'd6);
        bus.in_valid = 4'b0010;
        bus.cfg_mask = 8'hA5;
        bus.cfg_load = 1'b1;
        step();
        bus.in_valid = '0;
        bus.cfg_load = 1'b0;
        chk("cfg_coinc_old", bus.mul_mask, 8'h03);
        repeat (6) step();
        set_ch(2, 15'd9, 15'd9);
        bus.in_valid = 4'b0100;
        step();
        bus.in_valid = '0;
        chk("cfg_coinc_new", bus.mul_mask, 8'hA5);
        repeat (6) step();

        // reset during ISSUE_Q
        set_ch(2, 15'd11, 15'd12);
        bus.in_valid = 4'b0100;
        step();
        bus.in_valid = '0;
        step();
        chk("rst_mid_in_q", bus.mul_x, 15'd12);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_mul_x", bus.mul_x, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rst_no_out", bus.out_valid, 0);
        end
        bus.in_valid = 4'hF;
        #1;
        chk("rst_grant_ch0", bus.in_ready, 4'b0001);
        step();
        bus.in_valid = '0;
        repeat (6) step();

        // random traffic checked by the reference model
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = N'($urandom);
            bus.in_i      = {$urandom, $urandom};
            bus.in_q      = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.cfg_load  = ($urandom_range(0, 7) == 0);
            bus.cfg_mask  = 8'($urandom);
            step();
        end
        bus.in_valid  = '0;
        bus.cfg_load  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
